// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: program-counter sequencer for an instruction fetch port.
// A three-state FSM (BOOT, FETCH, HOLD) issues fetch requests for the
// registered pc. It advances pc on each completed fetch, takes redirects
// from br_valid/br_target, and withdraws the request while stalled.
module pc_seq_ctrl #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [WIDTH-1:0]  br_target,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic [WIDTH-1:0]  pc,
    output logic [1:0]        state,
    output logic [7:0]        fetch_cnt
);

    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        FETCH  = 2'b01,
        HOLD   = 2'b10,
        UNUSED = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [7:0]        cnt_q, cnt_d;

    // State register; reset wins over everything and lands in BOOT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Every FETCH outcome (branch, completed fetch,
    // withdrawn request, waiting) goes to HOLD exactly when stall is high,
    // so FETCH and HOLD share the same stall-driven transition.
    always_comb begin
        state_d = BOOT;
        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   state_d = stall ? HOLD : FETCH;
            HOLD:    state_d = stall ? HOLD : FETCH;
            default: state_d = BOOT;
        endcase
    end

    // Next pc and fetch counter. A branch outranks a simultaneous ready,
    // so that fetch is neither counted nor allowed to advance pc.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        case (state_q)
            FETCH: begin
                if (br_valid) begin
                    pc_d = br_target;
                end else if (imem_ready) begin
                    pc_d  = pc_q + WIDTH'(1);
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (br_valid) begin
                    pc_d = br_target;
                end
            end
            default: begin
                pc_d  = pc_q;
                cnt_d = cnt_q;
            end
        endcase
    end

    // pc and counter registers; both wrap naturally at their widths.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            cnt_q <= 8'd0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        imem_req  = (state_q == FETCH);
        state     = state_q;
        pc        = pc_q;
        fetch_cnt = cnt_q;
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: scoreboard bench for pc_seq_ctrl. The stimulus process
// drives inputs on the falling edge, steps a behavioural model and queues
// the expected outputs; the monitor pops and compares after each rising edge.
module tb_pc_seq_ctrl;

    localparam int W = 8;

    logic          clk;
    logic          reset;
    logic          stall;
    logic          brValid;
    logic [W-1:0]  brTarget;
    logic          imemReady;
    logic          imemReq;
    logic [W-1:0]  pcOut;
    logic [1:0]    stateOut;
    logic [7:0]    fetchCnt;

    typedef struct {
        int    pc;
        int    st;
        int    req;
        int    cnt;
        string tag;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    int   mMode;
    int   mPc;
    int   mCnt;

    pc_seq_ctrl #(.WIDTH(W), .RESET_VEC(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_valid   (brValid),
        .br_target  (brTarget),
        .imem_ready (imemReady),
        .imem_req   (imemReq),
        .pc         (pcOut),
        .state      (stateOut),
        .fetch_cnt  (fetchCnt)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, advance the model by the fetch rules and
    // queue what the outputs must show after the coming rising edge.
    task automatic applyStimulus(input logic rst, input logic stl,
                                 input logic brv, input int tgt,
                                 input logic rdy, input string tag);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        stall     = stl;
        brValid   = brv;
        brTarget  = tgt[W-1:0];
        imemReady = rdy;
        if (rst) begin
            mMode = 0;
            mPc   = 0;
            mCnt  = 0;
        end else if (mMode == 0) begin
            mMode = 1;
        end else begin
            if (brv) begin
                mPc = tgt % 256;
            end else if (mMode == 1 && rdy) begin
                mPc  = (mPc + 1) % 256;
                mCnt = (mCnt + 1) % 256;
            end
            mMode = stl ? 2 : 1;
        end
        e.pc  = mPc;
        e.st  = mMode;
        e.req = (mMode == 1) ? 1 : 0;
        e.cnt = mCnt;
        e.tag = tag;
        expQ.push_back(e);
    endtask

    // Compare every visible output against one queued expectation.
    task automatic checkOutput(input exp_t e);
        checks++;
        if (int'(pcOut) != e.pc) begin
            errors++;
            $display("[TB] FAIL %s.pc got %0h expected %0h", e.tag, pcOut, e.pc);
        end
        checks++;
        if (int'(stateOut) != e.st) begin
            errors++;
            $display("[TB] FAIL %s.state got %0d expected %0d", e.tag, stateOut, e.st);
        end
        checks++;
        if (int'(imemReq) != e.req) begin
            errors++;
            $display("[TB] FAIL %s.imem_req got %0d expected %0d", e.tag, imemReq, e.req);
        end
        checks++;
        if (int'(fetchCnt) != e.cnt) begin
            errors++;
            $display("[TB] FAIL %s.fetch_cnt got %0h expected %0h", e.tag, fetchCnt, e.cnt);
        end
    endtask

    // Monitor: sample shortly after each rising edge and score the result.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        int waitCycles;
        reset     = 1'b1;
        stall     = 1'b0;
        brValid   = 1'b0;
        brTarget  = '0;
        imemReady = 1'b0;
        mMode     = 0;
        mPc       = 0;
        mCnt      = 0;

        // Reset, one BOOT cycle, then back-to-back fetches from pc 0.
        applyStimulus(1, 0, 0, 0, 1, "reset");
        applyStimulus(1, 0, 0, 0, 1, "reset");
        applyStimulus(0, 0, 0, 0, 1, "boot");
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, "seqfetch");

        // Redirect to 0xFE, then two completed fetches wrap pc to 0x00.
        applyStimulus(0, 0, 1, 8'hFE, 0, "br_fe");
        applyStimulus(0, 0, 0, 0, 1, "wrap");
        applyStimulus(0, 0, 0, 0, 1, "wrap");

        // Branch with simultaneous ready: branch wins, count untouched.
        applyStimulus(0, 0, 1, 8'h10, 0, "br_10");
        applyStimulus(0, 0, 1, 8'h40, 1, "br_vs_ready");
        applyStimulus(0, 0, 0, 0, 0, "wait");

        // Stall with no ready withdraws the request; resume at same pc.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, "stall_hold");
        applyStimulus(0, 0, 0, 0, 0, "resume");
        applyStimulus(0, 0, 0, 0, 1, "resume_fetch");

        // Redirect while held stays in HOLD, then fetch from the target.
        applyStimulus(0, 1, 0, 0, 0, "to_hold");
        applyStimulus(0, 1, 1, 8'h80, 0, "hold_br");
        applyStimulus(0, 1, 0, 0, 0, "hold_stay");
        applyStimulus(0, 0, 0, 0, 0, "hold_exit");
        applyStimulus(0, 0, 0, 0, 1, "fetch_80");

        // Build pc=0x23, fetch_cnt=5, then reset mid-fetch and in HOLD.
        applyStimulus(1, 0, 0, 0, 0, "reset2");
        applyStimulus(0, 0, 0, 0, 0, "boot2");
        applyStimulus(0, 0, 1, 8'h1E, 0, "br_1e");
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, "count5");
        applyStimulus(1, 0, 1, 8'h55, 1, "reset_fetch");
        applyStimulus(0, 0, 0, 0, 0, "boot3");
        applyStimulus(0, 1, 0, 0, 0, "hold_again");
        applyStimulus(1, 1, 1, 8'h66, 0, "reset_hold");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 5) == 0),
                          int'($urandom_range(0, 255)),
                          ($urandom_range(0, 1) == 1),
                          "random");
        end

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d pending expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, PC width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 0, PC value loaded by reset.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 SHALL have port stall  input  1  pipeline stall request.
REQ-006 SHALL have port br_valid  input  1  redirect request, one-cycle qualifier for br_target.
REQ-007 SHALL have port br_target  input  WIDTH  redirect address.
REQ-008 SHALL have port imem_ready  input  1  instruction memory accepts the current request.
REQ-009 SHALL have port imem_req  output  1  fetch request for address pc.
REQ-010 SHALL have port pc  output  WIDTH  current fetch address, registered.
REQ-011 SHALL have port state  output  2  FSM state: BOOT=00, FETCH=01, HOLD=10; 11 unused.
REQ-012 SHALL have port fetch_cnt  output  8  count of completed fetches, registered.

Function
REQ-013 SHALL drive imem_req = 1 exactly when state==FETCH (Moore output, no combinational path from inputs).
REQ-014 SHALL define a completed fetch as state==FETCH & imem_ready==1 & br_valid==0 at a posedge.
REQ-015 BOOT: imem_req=0, pc held, all inputs ignored; next state FETCH unconditionally (one cycle).
REQ-016 FETCH, priority 1: br_valid=1 -> pc<=br_target, fetch_cnt unchanged, next FETCH if stall=0 else HOLD.
REQ-017 FETCH, priority 2: completed fetch -> pc<=pc+1, fetch_cnt<=fetch_cnt+1, next FETCH if stall=0 else HOLD.
REQ-018 FETCH, priority 3: imem_ready=0 & stall=1 -> pc unchanged, next HOLD (request withdrawn).
REQ-019 FETCH, otherwise: pc and fetch_cnt unchanged, remain FETCH (request held stable).
REQ-020 HOLD: imem_req=0; br_valid=1 -> pc<=br_target; next FETCH when stall=0, else HOLD.
REQ-021 pc increment SHALL wrap modulo 2^WIDTH (all-ones + 1 -> 0), no flag.
REQ-022 fetch_cnt SHALL wrap modulo 256 (0xFF + 1 -> 0x00).
REQ-023 pc SHALL be stable while imem_req=1 and imem_ready=0, unless br_valid=1.
REQ-024 Unused state encoding 11 SHALL transition to BOOT on the next posedge.
REQ-025 Branch takes precedence over simultaneous imem_ready; that fetch SHALL NOT be counted or advance pc.

Reset
REQ-026 reset=1 at a posedge SHALL set state=BOOT, pc=RESET_VEC, fetch_cnt=0, imem_req=0 next cycle.
REQ-027 Reset SHALL take priority over all other inputs in every state, including mid-fetch and in HOLD.
REQ-028 First imem_req=1 SHALL occur in the second cycle after reset deasserts (one BOOT cycle).

Verification
REQ-029 Reset release, imem_ready=1, stall=0 for 4 cycles after BOOT -> pc 0,1,2,3,4; fetch_cnt 0..4; imem_req=1 from cycle after BOOT.
REQ-030 WIDTH=8, pc=0xFE in FETCH, imem_ready=1 two cycles -> pc 0xFF then 0x00; fetch_cnt +2.
REQ-031 FETCH pc=0x10, imem_ready=1 and br_valid=1, br_target=0x40 same cycle -> pc=0x40, fetch_cnt unchanged, state FETCH.
REQ-032 FETCH imem_ready=0, stall=1 for 3 cycles, then stall=0 -> state HOLD, imem_req=0, pc unchanged; FETCH resumes with same pc.
REQ-033 HOLD with br_valid=1, br_target=0x80, stall=1 -> pc=0x80, state stays HOLD; stall=0 -> FETCH at 0x80.
REQ-034 reset=1 asserted in FETCH with pc=0x23, fetch_cnt=0x05 -> next cycle pc=RESET_VEC, fetch_cnt=0, state BOOT, imem_req=0.
